// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and scheduler state encoding
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync active level: 0 means active-low pulses.
  localparam logic SYNC_POL = 1'b0;

  localparam int FRAME_W = 8;

  // Scheduler states, kept as plain constants for legacy tools.
  typedef logic [0:0] sched_state_t;
  localparam sched_state_t IDLE = 1'b0;
  localparam sched_state_t REQ  = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping raster axis counter with next-count window decode
module vga_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int VISIBLE    = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [9:0] count,
  output logic [9:0] next_count,
  output logic       wrap,
  output logic       sync_win,
  output logic       visible_win
);

  localparam logic [9:0] LAST   = 10'(TOTAL - 1);
  localparam logic [9:0] SYNC_S = 10'(SYNC_START);
  localparam logic [9:0] SYNC_E = 10'(SYNC_END);
  localparam logic [9:0] VIS    = 10'(VISIBLE);

  // Windows decode the value the counter is about to take, so a register
  // stage in the parent lines the flags up with the displayed count.
  always_comb begin
    wrap        = step && (count == LAST);
    next_count  = wrap ? 10'd0 : (step ? count + 10'd1 : count);
    sync_win    = (next_count >= SYNC_S) && (next_count < SYNC_E);
    visible_win = (next_count < VIS);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 10'd0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - VGA raster timing plus one animation request per frame in vblank
module vga_frame_scheduler #(
  parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK    = vga_timing_pkg::H_BACK,
  parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic SYNC_POL  = vga_timing_pkg::SYNC_POL,
  parameter int   FRAME_W   = vga_timing_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pause,
  input  logic               anim_ack,
  input  logic               overrun_clr,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank,
  output logic               anim_req,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               anim_overrun
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_VIS_L = 10'(V_VISIBLE);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_frame_scheduler: raster totals exceed the 10-bit counter range");
  end

  logic [9:0]   h_next, v_next;
  logic         h_wrap, v_wrap;
  logic         h_sync_win, v_sync_win, h_vis, v_vis;
  logic         vb_start_n, deadline_n, overrun_set;
  sched_state_t state;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC),
    .VISIBLE    (H_VISIBLE)
  ) u_h_counter (
    .clk         (clk),
    .rst         (rst),
    .step        (1'b1),
    .count       (hpos),
    .next_count  (h_next),
    .wrap        (h_wrap),
    .sync_win    (h_sync_win),
    .visible_win (h_vis)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC),
    .VISIBLE    (V_VISIBLE)
  ) u_v_counter (
    .clk         (clk),
    .rst         (rst),
    .step        (h_wrap),
    .count       (vpos),
    .next_count  (v_next),
    .wrap        (v_wrap),
    .sync_win    (v_sync_win),
    .visible_win (v_vis)
  );

  // Scheduler events, decoded on the position about to be shown; a vertical
  // wrap is exactly the step into (0,0), which ends the blanking window.
  always_comb begin
    vb_start_n  = (h_next == 10'd0) && (v_next == V_VIS_L);
    deadline_n  = v_wrap;
    overrun_set = (state == REQ) && !anim_ack && deadline_n;
  end

  // Registered raster flags, aligned with hpos/vpos of the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      hsync       <= h_sync_win ? SYNC_POL : ~SYNC_POL;
      vsync       <= v_sync_win ? SYNC_POL : ~SYNC_POL;
      display_on  <= h_vis && v_vis;
      line_start  <= (h_next == 10'd0);
      frame_start <= v_wrap;
      vblank      <= !v_vis;
    end
  end

  // Request FSM: raise at vblank start unless paused, drop on ack or deadline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      anim_req  <= 1'b0;
      frame_cnt <= '0;
    end else if (state == IDLE) begin
      if (vb_start_n && !pause) begin
        state     <= REQ;
        anim_req  <= 1'b1;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end else begin
      if (anim_ack || deadline_n) begin
        state    <= IDLE;
        anim_req <= 1'b0;
      end
    end
  end

  // Sticky overrun flag; a new miss beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      anim_overrun <= 1'b0;
    end else if (overrun_set) begin
      anim_overrun <= 1'b1;
    end else if (overrun_clr) begin
      anim_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb/tb_vga_frame_scheduler.sv - self-checking bench for vga_frame_scheduler on a shrunken raster
module tb_vga_frame_scheduler;

  localparam int HV = 6, HF = 1, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic       anim_ack = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [9:0] hpos, vpos;
  logic       hsync, vsync, display_on, line_start, frame_start, vblank;
  logic       anim_req, anim_overrun;
  logic [7:0] frame_cnt;

  vga_frame_scheduler #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .FRAME_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .anim_ack(anim_ack),
    .overrun_clr(overrun_clr), .hpos(hpos), .vpos(vpos), .hsync(hsync),
    .vsync(vsync), .display_on(display_on), .line_start(line_start),
    .frame_start(frame_start), .vblank(vblank), .anim_req(anim_req),
    .frame_cnt(frame_cnt), .anim_overrun(anim_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: mt = cycles shown since reset released (0 = the reset pixel).
  int       mt = 0;
  bit       mreq = 0;
  bit       movr = 0;
  logic [7:0] mfc = 8'd0;
  int       mage = 0;
  int       rmode = 1;
  bit       rand_ctl = 0;
  bit       rand_pause = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (model t=%0d)", name, act, exp, mt);
    end
  endtask

  function automatic bit at_pos(input int h, input int v);
    return ((mt % HT) == h) && (((mt / HT) % VT) == v);
  endfunction

  task automatic compare();
    int  h, v;
    bit  live;
    h = mt % HT;
    v = (mt / HT) % VT;
    live = (mt != 0);
    check("hpos", int'(hpos), h);
    check("vpos", int'(vpos), v);
    check("hsync", int'(hsync), (h >= HV + HF && h < HV + HF + HS) ? 0 : 1);
    check("vsync", int'(vsync), (v >= VV + VF && v < VV + VF + VS) ? 0 : 1);
    check("display_on", int'(display_on), int'(live && h < HV && v < VV));
    check("line_start", int'(line_start), int'(live && h == 0));
    check("frame_start", int'(frame_start), int'(live && h == 0 && v == 0));
    check("vblank", int'(vblank), int'(live && v >= VV));
    check("anim_req", int'(anim_req), int'(mreq));
    check("frame_cnt", int'(frame_cnt), int'(mfc));
    check("anim_overrun", int'(anim_overrun), int'(movr));
  endtask

  task automatic model_advance();
    int nh, nv;
    bit was, set_o;
    was = mreq;
    if (rst) begin
      mt = 0; mreq = 0; mfc = 8'd0; movr = 0;
    end else begin
      mt++;
      nh = mt % HT;
      nv = (mt / HT) % VT;
      set_o = 0;
      if (!mreq) begin
        if (nh == 0 && nv == VV && !pause) begin
          mreq = 1;
          mfc = mfc + 8'd1;
        end
      end else if (anim_ack) begin
        mreq = 0;
      end else if (nh == 0 && nv == 0) begin
        mreq = 0;
        set_o = 1;
      end
      if (set_o) movr = 1;
      else if (overrun_clr) movr = 0;
    end
    if (mreq && !was) mage = 0;
    else if (mreq) mage++;
  endtask

  task automatic drive();
    if (rand_ctl) begin
      if (mt % FT == 0) rand_pause = ($urandom % 3 == 0);
      pause = rand_pause;
      overrun_clr = ($urandom % 16 == 0);
    end
    case (rmode)
      0: anim_ack = mreq && (mage == 10);
      1: anim_ack = 1'b0;
      default: anim_ack = ($urandom % 8 == 0);
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      model_advance();
      @(negedge clk);
      compare();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c_line, c_frame, c_disp, c_hlow, c_vlow, c_req, k;

    // Reset state, including the (0,0) pixel shown right after reset.
    rmode = 1;
    run(3);
    check("rst_hpos", int'(hpos), 0);
    check("rst_vpos", int'(vpos), 0);
    check("rst_anim_req", int'(anim_req), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_overrun", int'(anim_overrun), 0);
    check("rst_display_on", int'(display_on), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);

    // One full frame with the renderer acking 10 cycles after the request.
    rst = 1'b0;
    rmode = 0;
    c_line = 0; c_frame = 0; c_disp = 0; c_hlow = 0; c_vlow = 0; c_req = 0;
    for (int i = 0; i < FT; i++) begin
      run(1);
      c_line  += int'(line_start);
      c_frame += int'(frame_start);
      c_disp  += int'(display_on);
      c_hlow  += int'(!hsync);
      c_vlow  += int'(!vsync);
      c_req   += int'(anim_req);
    end
    check("line_start_count", c_line, 8);
    check("frame_start_count", c_frame, 1);
    check("display_on_count", c_disp, 24);
    check("hsync_low_count", c_hlow, 16);
    check("vsync_low_count", c_vlow, 11);
    check("req_cycles_acked", c_req, 11);
    check("frame_start_at_origin", int'(frame_start && hpos == 0 && vpos == 0), 1);
    check("frame_cnt_after_ack", int'(frame_cnt), 1);
    check("overrun_after_ack", int'(anim_overrun), 0);

    // Renderer never acks: request spans the whole blanking, then overrun.
    rmode = 1;
    c_req = 0;
    for (int i = 0; i < FT; i++) begin
      run(1);
      c_req += int'(anim_req);
    end
    check("req_cycles_noack", c_req, 44);
    check("req_at_deadline", int'(anim_req), 0);
    check("overrun_on_miss", int'(anim_overrun), 1);
    check("frame_cnt_after_miss", int'(frame_cnt), 2);

    // Clear pulse.
    overrun_clr = 1'b1;
    run(1);
    overrun_clr = 1'b0;
    check("overrun_cleared", int'(anim_overrun), 0);
    run(1);

    // Clear held across a fresh deadline miss: the set wins.
    overrun_clr = 1'b1;
    k = 0;
    do begin
      run(1);
      k++;
    end while (mt % FT != 0 && k < 3 * FT);
    check("clr_vs_set_reached", int'(mt % FT == 0), 1);
    check("clr_vs_set_overrun", int'(anim_overrun), 1);
    overrun_clr = 1'b0;
    run(1);
    overrun_clr = 1'b1;
    run(1);
    overrun_clr = 1'b0;
    check("overrun_cleared_again", int'(anim_overrun), 0);
    check("frame_cnt_before_pause", int'(frame_cnt), 3);

    // Pause across a vblank start: no request, count held.
    pause = 1'b1;
    rmode = 0;
    c_req = 0;
    for (int i = 0; i < FT; i++) begin
      run(1);
      c_req += int'(anim_req);
    end
    check("paused_req_cycles", c_req, 0);
    check("paused_frame_cnt", int'(frame_cnt), 3);
    pause = 1'b0;

    // Randomized pause/ack/clear traffic against the model.
    rand_ctl = 1;
    rmode = 2;
    run(40 * FT);
    rand_ctl = 0;
    pause = 1'b0;
    overrun_clr = 1'b0;
    rmode = 0;

    // Count up to 255, then watch the next vblank start wrap it to 0.
    k = 0;
    while (!(mreq && mage == 0 && mfc == 8'd255 && at_pos(0, VV)) && k < 300 * FT) begin
      run(1);
      k++;
    end
    check("wrap_reached_255", int'(frame_cnt), 255);
    k = 0;
    do begin
      run(1);
      k++;
    end while (!(mreq && mage == 0) && k < 2 * FT);
    check("frame_cnt_wrap", int'(frame_cnt), 0);
    check("wrap_anim_req", int'(anim_req), 1);

    // Reset mid-request at (3,5) of the following frame.
    rmode = 1;
    k = 0;
    while (!(at_pos(3, 5) && mfc == 8'd1 && mreq) && k < 3 * FT) begin
      run(1);
      k++;
    end
    check("pre_reset_req", int'(anim_req), 1);
    check("pre_reset_frame_cnt", int'(frame_cnt), 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("midreset_hpos", int'(hpos), 0);
    check("midreset_vpos", int'(vpos), 0);
    check("midreset_anim_req", int'(anim_req), 0);
    check("midreset_frame_cnt", int'(frame_cnt), 0);
    check("midreset_overrun", int'(anim_overrun), 0);
    rmode = 0;
    run(2 * FT);
    check("post_reset_frame_cnt", int'(frame_cnt), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
